// File: rtl/me_search_sequencer.sv
// Sequencer for one full-search motion-estimation pass over a single 8x8 block:
// loads CurBuffer, paces RefSRAM line by line, issues candidates and keeps the minimum SAD.
module me_search_sequencer #(
  parameter int unsigned EDGE_LEN = 8,
  parameter int unsigned SEARCH_W = 16,
  parameter int unsigned SEARCH_H = 16,
  parameter int unsigned CUR_LOAD = 16,
  parameter int unsigned AD_LAT   = 4,
  parameter int unsigned SAD_W    = 14,
  localparam int unsigned XW      = $clog2(SEARCH_W),
  localparam int unsigned YW      = $clog2(SEARCH_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sram_ready,
  input  logic [SAD_W-1:0] sad_in,
  output logic             cur_read_start,
  output logic             cur_read_en,
  output logic             ref_next_line,
  output logic             cur_next_block,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [XW-1:0]    best_x,
  output logic [YW-1:0]    best_y
);

  localparam int unsigned CW = $clog2(CUR_LOAD + EDGE_LEN + AD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CUR, S_WAIT_REF, S_FILL, S_SCAN, S_DRAIN, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [XW-1:0]             col_q, col_d;
  logic [YW-1:0]             row_q, row_d;
  logic                      ready_q, ready_d;
  logic [AD_LAT-1:0]         pv_q, pv_d;
  logic [AD_LAT-1:0][XW-1:0] pc_q, pc_d;
  logic [AD_LAT-1:0][YW-1:0] pr_q, pr_d;
  logic [SAD_W-1:0]          min_q, min_d;
  logic [XW-1:0]             min_x_q, min_x_d;
  logic [YW-1:0]             min_y_q, min_y_d;
  logic                      cur_read_start_q, cur_read_start_d;
  logic                      cur_read_en_q, cur_read_en_d;
  logic                      ref_next_line_q, ref_next_line_d;
  logic                      cur_next_block_q, cur_next_block_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [SAD_W-1:0]          best_sad_q, best_sad_d;
  logic [XW-1:0]             best_x_q, best_x_d;
  logic [YW-1:0]             best_y_q, best_y_d;

  // Next-state, pipe shift, running minimum and registered output decode
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    col_d            = col_q;
    row_d            = row_q;
    ready_d          = ready_q | sram_ready;
    min_d            = min_q;
    min_x_d          = min_x_q;
    min_y_d          = min_y_q;
    cur_read_start_d = 1'b0;
    ref_next_line_d  = 1'b0;
    best_sad_d       = best_sad_q;
    best_x_d         = best_x_q;
    best_y_d         = best_y_q;

    pv_d[0] = (state_q == S_SCAN);
    pc_d[0] = col_q;
    pr_d[0] = row_q;
    for (int i = 1; i < int'(AD_LAT); i++) begin
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
      pr_d[i] = pr_q[i-1];
    end

    // Strict compare: on ties the candidate scanned first is kept
    if (pv_q[AD_LAT-1] && (sad_in < min_q)) begin
      min_d   = sad_in;
      min_x_d = pc_q[AD_LAT-1];
      min_y_d = pr_q[AD_LAT-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d          = S_LOAD_CUR;
          cnt_d            = '0;
          col_d            = '0;
          row_d            = '0;
          min_d            = '1;
          min_x_d          = '0;
          min_y_d          = '0;
          cur_read_start_d = 1'b1;
        end
      end
      S_LOAD_CUR: begin
        if (cnt_q == CW'(CUR_LOAD - 1)) begin
          state_d = S_WAIT_REF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_REF: begin
        // A pulse landing on the consume cycle re-arms the flag
        if (ready_q) begin
          state_d = S_FILL;
          ready_d = sram_ready;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (cnt_q == CW'(EDGE_LEN - 1)) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SCAN: begin
        if (col_q == XW'(SEARCH_W - 1)) begin
          col_d = '0;
          cnt_d = '0;
          if (row_q != YW'(SEARCH_H - 1)) begin
            row_d           = row_q + YW'(1);
            ref_next_line_d = 1'b1;
            state_d         = S_WAIT_REF;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          col_d = col_q + XW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(AD_LAT - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cur_read_en_d    = (state_d == S_LOAD_CUR);
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
    cur_next_block_d = (state_d == S_DONE);
    // Results publish together with done; the last tail compare is folded in via min_d
    if (state_d == S_DONE) begin
      best_sad_d = min_d;
      best_x_d   = min_x_d;
      best_y_d   = min_y_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      col_q            <= '0;
      row_q            <= '0;
      ready_q          <= 1'b0;
      pv_q             <= '0;
      pc_q             <= '0;
      pr_q             <= '0;
      min_q            <= '1;
      min_x_q          <= '0;
      min_y_q          <= '0;
      cur_read_start_q <= 1'b0;
      cur_read_en_q    <= 1'b0;
      ref_next_line_q  <= 1'b0;
      cur_next_block_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      best_sad_q       <= '1;
      best_x_q         <= '0;
      best_y_q         <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      col_q            <= col_d;
      row_q            <= row_d;
      ready_q          <= ready_d;
      pv_q             <= pv_d;
      pc_q             <= pc_d;
      pr_q             <= pr_d;
      min_q            <= min_d;
      min_x_q          <= min_x_d;
      min_y_q          <= min_y_d;
      cur_read_start_q <= cur_read_start_d;
      cur_read_en_q    <= cur_read_en_d;
      ref_next_line_q  <= ref_next_line_d;
      cur_next_block_q <= cur_next_block_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      best_sad_q       <= best_sad_d;
      best_x_q         <= best_x_d;
      best_y_q         <= best_y_d;
    end
  end

  assign cur_read_start = cur_read_start_q;
  assign cur_read_en    = cur_read_en_q;
  assign ref_next_line  = ref_next_line_q;
  assign cur_next_block = cur_next_block_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign best_sad       = best_sad_q;
  assign best_x         = best_x_q;
  assign best_y         = best_y_q;

endmodule

// File: tb/tb_me_search_sequencer.sv
// Self-checking bench for me_search_sequencer: per-scenario tasks against a
// cycle-schedule model of the pass and an argmin model of the search.
module tb_me_search_sequencer;

  localparam int SH = 16;
  localparam int SW = 16;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        start      = 1'b0;
  logic        sram_ready = 1'b0;
  logic [13:0] sad_in     = '0;
  logic        cur_read_start, cur_read_en, ref_next_line, cur_next_block, busy, done;
  logic [13:0] best_sad;
  logic [3:0]  best_x, best_y;

  me_search_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .sram_ready(sram_ready), .sad_in(sad_in),
    .cur_read_start(cur_read_start), .cur_read_en(cur_read_en), .ref_next_line(ref_next_line),
    .cur_next_block(cur_next_block), .busy(busy), .done(done),
    .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int tbl [SH][SW];
  int es, ex, ey, prev_sad;
  int o_s, o_pred, o_done_cnt, o_done_edge, o_crs_cnt, o_crs_edge;
  int o_rnl_cnt, o_rnl_bad, o_en_cnt, o_en_bad, o_busy_bad, o_cnb_bad;
  logic [13:0] o_sad, o_mid;
  logic [3:0]  o_x, o_y;

  // Best = smallest value; among equals, the first in row-major scan order
  function automatic void model();
    int  m = 16383;
    bit  found = 1'b0;
    es = 16383; ex = 0; ey = 0;
    for (int y = 0; y < SH; y++) for (int x = 0; x < SW; x++) if (tbl[y][x] < m) m = tbl[y][x];
    if (m < 16383) begin
      es = m;
      for (int y = 0; y < SH; y++)
        for (int x = 0; x < SW; x++)
          if (!found && tbl[y][x] == m) begin ex = x; ey = y; found = 1'b1; end
    end
  endfunction

  task automatic fill_const(input int v);
    for (int y = 0; y < SH; y++) for (int x = 0; x < SW; x++) tbl[y][x] = v;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < SH; y++) for (int x = 0; x < SW; x++) tbl[y][x] = int'($urandom_range(0, 63));
  endtask

  // Drives one pass. g = cycles from WAIT_REF entry to the sampled sram_ready
  // (0: ready always pending early; 3: pulse 2 cycles after each ref_next_line).
  // Row r's FILL starts 1 cycle after edge s+16+g+r*(25+g); sad for column c is
  // presented 13+c cycles after that edge; done lands 29 cycles after the last row's.
  task automatic run_pass(input int g, input bit hold, input bit zero_bg, input int abort_at);
    int n, m, base, pend;
    bit hit;
    o_done_cnt = 0; o_done_edge = -1; o_crs_cnt = 0; o_crs_edge = -1; o_rnl_cnt = 0;
    o_rnl_bad = 0; o_en_cnt = 0; o_en_bad = 0; o_busy_bad = 0; o_cnb_bad = 0;
    o_sad = '0; o_x = '0; o_y = '0; o_mid = '0;
    @(negedge clk);
    start  = 1'b1;
    o_s    = cyc + 1;
    o_pred = o_s + 16 + g + 15 * (25 + g) + 29;
    pend   = (g == 0) ? o_s + 4 : o_s + 18;
    for (int k = 0; k < 800; k++) begin
      n = cyc;
      if (abort_at > 0 && n == o_s + abort_at) begin rst = 1'b1; break; end
      if (hold ? (done === 1'b1) : (n >= o_s)) start = 1'b0;
      if (cur_read_start === 1'b1) begin o_crs_cnt++; o_crs_edge = n; end
      if (cur_read_en === 1'b1) begin o_en_cnt++; if (n < o_s || n > o_s + 15) o_en_bad++; end
      if (ref_next_line === 1'b1) begin
        o_rnl_cnt++;
        m = n - (o_s + 16);
        if (m <= 0 || m % (25 + g) != 0 || m / (25 + g) > 15) o_rnl_bad++;
        if (g != 0) pend = n + 2;
      end
      if (busy !== (n >= o_s && n <= o_pred)) o_busy_bad++;
      if (done === 1'b1) begin
        o_done_cnt++; o_done_edge = n; o_sad = best_sad; o_x = best_x; o_y = best_y;
      end
      if (cur_next_block !== done) o_cnb_bad++;
      if (n == o_s + 100) o_mid = best_sad;
      m = n - (o_s + 25);
      sram_ready = (n == pend) || (g == 0 && m >= 0 && m % 25 == 0 && m / 25 <= 14);
      hit = 1'b0;
      for (int r = 0; r < SH; r++) begin
        base = o_s + 29 + g + r * (25 + g);
        if (n >= base && n < base + 16) begin sad_in = 14'(tbl[r][n - base]); hit = 1'b1; end
      end
      if (!hit) sad_in = zero_bg ? 14'd0 : 14'($urandom);
      if (n >= o_pred + 3) break;
      @(negedge clk);
    end
    start = 1'b0; sram_ready = 1'b0; sad_in = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_held: got %0d want 0", busy); end
    n_cmp++; if (best_sad !== 14'd16383) begin n_bad++; $display("FAIL rst_best_sad_held: got %0d want 16383", best_sad); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0d want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0d want 0", done); end
    n_cmp++; if (cur_read_start !== 1'b0) begin n_bad++; $display("FAIL rst_crs: got %0d want 0", cur_read_start); end
    n_cmp++; if (cur_read_en !== 1'b0) begin n_bad++; $display("FAIL rst_cre: got %0d want 0", cur_read_en); end
    n_cmp++; if (ref_next_line !== 1'b0) begin n_bad++; $display("FAIL rst_rnl: got %0d want 0", ref_next_line); end
    n_cmp++; if (cur_next_block !== 1'b0) begin n_bad++; $display("FAIL rst_cnb: got %0d want 0", cur_next_block); end
    n_cmp++; if (best_sad !== 14'd16383) begin n_bad++; $display("FAIL rst_best_sad: got %0d want 16383", best_sad); end
    n_cmp++; if (best_x !== 4'd0) begin n_bad++; $display("FAIL rst_best_x: got %0d want 0", best_x); end
    n_cmp++; if (best_y !== 4'd0) begin n_bad++; $display("FAIL rst_best_y: got %0d want 0", best_y); end
    prev_sad = 16383;
  endtask

  task automatic test_single_pass();
    fill_const(1000); tbl[9][5] = 37;
    run_pass(3, 1'b0, 1'b0, 0);
    n_cmp++; if (o_done_cnt != 1) begin n_bad++; $display("FAIL t2_done_count: got %0d want 1", o_done_cnt); end
    n_cmp++; if (o_sad !== 14'd37) begin n_bad++; $display("FAIL t2_best_sad: got %0d want 37", o_sad); end
    n_cmp++; if (o_x !== 4'd5) begin n_bad++; $display("FAIL t2_best_x: got %0d want 5", o_x); end
    n_cmp++; if (o_y !== 4'd9) begin n_bad++; $display("FAIL t2_best_y: got %0d want 9", o_y); end
    n_cmp++; if (o_rnl_cnt != 15) begin n_bad++; $display("FAIL t2_rnl_count: got %0d want 15", o_rnl_cnt); end
    n_cmp++; if (o_rnl_bad != 0) begin n_bad++; $display("FAIL t2_rnl_timing: got %0d misplaced want 0", o_rnl_bad); end
    n_cmp++; if (o_done_edge != o_pred) begin n_bad++; $display("FAIL t2_done_time: got %0d want %0d", o_done_edge - o_s, o_pred - o_s); end
    n_cmp++; if (o_en_cnt != 16 || o_en_bad != 0) begin n_bad++; $display("FAIL t2_read_en: got %0d cycles (%0d misplaced) want 16", o_en_cnt, o_en_bad); end
    n_cmp++; if (o_busy_bad != 0) begin n_bad++; $display("FAIL t2_busy: got %0d wrong cycles want 0", o_busy_bad); end
    n_cmp++; if (o_cnb_bad != 0) begin n_bad++; $display("FAIL t2_next_block: got %0d wrong cycles want 0", o_cnb_bad); end
    n_cmp++; if (o_mid !== 14'(prev_sad)) begin n_bad++; $display("FAIL t2_hold_mid: got %0d want %0d", o_mid, prev_sad); end
    prev_sad = 37;
  endtask

  task automatic test_tie();
    fill_const(500); tbl[2][3] = 200; tbl[2][7] = 200;
    run_pass(0, 1'b0, 1'b0, 0);
    n_cmp++; if (o_sad !== 14'd200) begin n_bad++; $display("FAIL t3_best_sad: got %0d want 200", o_sad); end
    n_cmp++; if (o_x !== 4'd3 || o_y !== 4'd2) begin n_bad++; $display("FAIL t3_best_xy: got (%0d,%0d) want (3,2)", o_x, o_y); end
    prev_sad = 200;
  endtask

  task automatic test_early_ready();
    fill_rand(); model();
    run_pass(0, 1'b0, 1'b0, 0);
    n_cmp++; if (o_done_edge - o_s + 2 != 422) begin n_bad++; $display("FAIL t4_pass_len: got %0d want 422", o_done_edge - o_s + 2); end
    n_cmp++; if (o_rnl_bad != 0 || o_rnl_cnt != 15) begin n_bad++; $display("FAIL t4_rnl: got %0d pulses (%0d misplaced) want 15", o_rnl_cnt, o_rnl_bad); end
    n_cmp++; if (o_sad !== 14'(es) || o_x !== 4'(ex) || o_y !== 4'(ey)) begin n_bad++; $display("FAIL t4_best: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", o_sad, o_x, o_y, es, ex, ey); end
    prev_sad = es;
  endtask

  task automatic test_start_held();
    fill_rand(); model();
    run_pass(0, 1'b1, 1'b0, 0);
    n_cmp++; if (o_done_cnt != 1) begin n_bad++; $display("FAIL t5_done_count: got %0d want 1", o_done_cnt); end
    n_cmp++; if (o_crs_cnt != 1 || o_crs_edge != o_s) begin n_bad++; $display("FAIL t5_read_start: got %0d pulses want 1 at IDLE exit", o_crs_cnt); end
    n_cmp++; if (o_busy_bad != 0) begin n_bad++; $display("FAIL t5_busy: got %0d wrong cycles want 0", o_busy_bad); end
    n_cmp++; if (o_sad !== 14'(es) || o_x !== 4'(ex) || o_y !== 4'(ey)) begin n_bad++; $display("FAIL t5_best: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", o_sad, o_x, o_y, es, ex, ey); end
    prev_sad = es;
  endtask

  task automatic test_invalid_ignored();
    fill_const(900); tbl[0][0] = 850;
    run_pass(3, 1'b0, 1'b1, 0);
    n_cmp++; if (o_sad !== 14'd850) begin n_bad++; $display("FAIL t6_best_sad: got %0d want 850", o_sad); end
    n_cmp++; if (o_x !== 4'd0 || o_y !== 4'd0) begin n_bad++; $display("FAIL t6_best_xy: got (%0d,%0d) want (0,0)", o_x, o_y); end
    prev_sad = 850;
  endtask

  task automatic test_reset_mid_scan();
    fill_rand();
    run_pass(0, 1'b0, 1'b0, 78);
    #1;
    n_cmp++; if ({busy, done, cur_read_en, cur_read_start, ref_next_line, cur_next_block} !== 6'b0) begin
      n_bad++; $display("FAIL t1_ctl_zero: got %b want 000000", {busy, done, cur_read_en, cur_read_start, ref_next_line, cur_next_block}); end
    n_cmp++; if (best_sad !== 14'd16383) begin n_bad++; $display("FAIL t1_best_sad: got %0d want 16383", best_sad); end
    n_cmp++; if (best_x !== 4'd0 || best_y !== 4'd0) begin n_bad++; $display("FAIL t1_best_xy: got (%0d,%0d) want (0,0)", best_x, best_y); end
    @(negedge clk); rst = 1'b0;
    prev_sad = 16383;
    fill_rand(); model();
    run_pass(0, 1'b0, 1'b0, 0);
    n_cmp++; if (o_crs_cnt != 1 || o_crs_edge != o_s || o_en_cnt != 16) begin n_bad++; $display("FAIL t1_restart: got %0d starts, %0d load cycles want 1, 16", o_crs_cnt, o_en_cnt); end
    n_cmp++; if (o_done_edge != o_pred) begin n_bad++; $display("FAIL t1_done_time: got %0d want %0d", o_done_edge - o_s, o_pred - o_s); end
    n_cmp++; if (o_sad !== 14'(es) || o_x !== 4'(ex) || o_y !== 4'(ey)) begin n_bad++; $display("FAIL t1_best: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", o_sad, o_x, o_y, es, ex, ey); end
    n_cmp++; if (o_mid !== 14'd16383) begin n_bad++; $display("FAIL t1_hold_mid: got %0d want 16383", o_mid); end
    prev_sad = es;
  endtask

  task automatic test_random();
    int g;
    for (int it = 0; it < 3; it++) begin
      g = ($urandom_range(0, 1) == 1) ? 3 : 0;
      fill_rand(); model();
      run_pass(g, 1'b0, 1'b0, 0);
      n_cmp++; if (o_sad !== 14'(es) || o_x !== 4'(ex) || o_y !== 4'(ey)) begin n_bad++; $display("FAIL rnd%0d_best: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", it, o_sad, o_x, o_y, es, ex, ey); end
      n_cmp++; if (o_done_cnt != 1 || o_done_edge != o_pred) begin n_bad++; $display("FAIL rnd%0d_done: got %0d pulses at %0d want 1 at %0d", it, o_done_cnt, o_done_edge - o_s, o_pred - o_s); end
      n_cmp++; if (o_mid !== 14'(prev_sad)) begin n_bad++; $display("FAIL rnd%0d_hold_mid: got %0d want %0d", it, o_mid, prev_sad); end
      prev_sad = es;
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_tie();
    test_early_ready();
    test_start_held();
    test_invalid_ignored();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
